reg_bank_arbiter: RTL and testbench
===================================

// Module: reg_bank_arbiter
// PURPOSE
//  Shares one bank of DEPTH WIDTH-bit structural flip-flop registers between two
//  writers: port 0 (weight loader) and port 1 (accumulator writeback). Grants the
//  bank in bounded bursts, round-robin between the ports. Drives a one-hot,
//  one-cycle write strobe plus write data into the bank's per-register D-select muxes.
// PARAMETERS
//  DEPTH     8   number of registers in the bank
//  AW        3   address width, clog2(DEPTH)
//  WIDTH     34  register data width (matches the 34-bit flip-flop bank)
//  MAXBURST  4   max beats per grant before forced re-arbitration (>=1)
// PORTS
//  C         in   1         clock, rising edge
//  Rn        in   1         asynchronous active-low reset
//  req       in   2         req[i]: port i wants the bank; held high through its burst
//  addr0     in   AW        port 0 beat address
//  data0     in   WIDTH     port 0 beat data
//  last0     in   1         port 0 final beat of burst
//  addr1     in   AW        port 1 beat address
//  data1     in   WIDTH     port 1 beat data
//  last1     in   1         port 1 final beat of burst
//  gnt       out  2         registered one-hot grant; at most one bit set
//  we        out  DEPTH     one-hot write strobe, one cycle per accepted beat
//  wdata     out  WIDTH     data for the register selected by we
//  err       out  1         one-cycle pulse: accepted beat had addr >= DEPTH
//  busy      out  1         1 while state != IDLE
// BEHAVIOUR
//  - Reset (Rn=0, async): state=IDLE, gnt=0, we=0, wdata=0, err=0, busy=0,
//    beat count=0, rr pointer=0 (port 0 favoured). A pending registered write is dropped.
//  - States: IDLE, OWN0, OWN1. gnt = {state==OWN1, state==OWN0}, registered.
//  - IDLE: req=01->OWN0; 10->OWN1; 11->port named by rr pointer; 00->stay.
//  - Beat: cycle with req[i]&gnt[i]. addr/data/last of port i sampled that cycle.
//  - Write latency 1: edge after a beat, we[addr]=1 and wdata=data for exactly
//    one cycle; otherwise we=0 and wdata holds its last value.
//  - addr >= DEPTH: beat counts toward the burst, we stays 0, err=1 for 1 cycle.
//  - Burst end: beat with last=1, or beat number MAXBURST (count==MAXBURST-1).
//    Next state: other port if it requests; else same port if req still high
//    (new burst, count=0); else IDLE. rr pointer -> other port at every burst end.
//  - Abandon: in OWNi with req[i]=0 (no beat): no write; next state = other
//    port if it requests, else IDLE; count=0; rr pointer -> other port.
//  - Beat counter: AW-independent, clog2(MAXBURST)+1 bits, cleared on grant change.
//  - Handover has no bubble: gnt switches on the edge after the ending beat;
//    a back-to-back beat from the new owner is accepted in the very next cycle.
//  - gnt never has both bits set; we is never multi-hot; we=0 whenever err=1.
// TESTING
//  1 Reset: Rn=0 mid-burst (OWN0, we pulsing) -> all outputs 0 immediately, IDLE.
//  2 Single: req=01, addr0=5, data0=34'h2_DEAD_BEEF, last0=1 -> gnt=01 next
//    cycle; beat; next cycle we=8'b0010_0000, wdata=34'h2_DEAD_BEEF; then IDLE.
//  3 Forced split: req=01 held, last0=0, 6 beats -> 4 writes, gnt drops to 00 for
//    0 cycles (re-grant port 0, count=0), remaining 2 beats written.
//  4 Contention: req=11 from IDLE after reset -> OWN0 first; at burst end gnt=10;
//    next end gnt=01; writes alternate per burst.
//  5 Bad addr: DEPTH=6, addr1=7 beat -> we=0, err=1 one cycle; burst continues.
//  6 Abandon: OWN1, req1 drops without last, req0=1 -> no write, gnt=01 next cycle.

Source files
------------

// File: rtl/reg_bank_arbiter.sv
// Round-robin burst arbiter: two writers share one register bank.
// Accepted beats become a registered one-hot write strobe plus write data.
module reg_bank_arbiter #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AW       = 3,
  parameter int unsigned WIDTH    = 34,
  parameter int unsigned MAXBURST = 4
) (
  input  logic             C,
  input  logic             Rn,
  input  logic [1:0]       req,
  input  logic [AW-1:0]    addr0,
  input  logic [WIDTH-1:0] data0,
  input  logic             last0,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] data1,
  input  logic             last1,
  output logic [1:0]       gnt,
  output logic [DEPTH-1:0] we,
  output logic [WIDTH-1:0] wdata,
  output logic             err,
  output logic             busy
);

  localparam int unsigned CW = $clog2(MAXBURST) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MAXBURST - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_rr;
  logic [1:0]       r_gnt;
  logic             r_busy;
  logic [DEPTH-1:0] r_we;
  logic [WIDTH-1:0] r_wdata;
  logic             r_err;

  logic [1:0]       w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_rr_nxt;
  logic [DEPTH-1:0] w_we_nxt;
  logic [WIDTH-1:0] w_wdata_nxt;
  logic             w_err_nxt;

  logic             w_own;
  logic             w_oth;
  logic             w_beat;
  logic [AW-1:0]    w_addr;
  logic [WIDTH-1:0] w_data;
  logic             w_last;
  logic             w_addr_ok;
  logic [1:0]       w_oth_state;

  // Current owner's beat signals; only meaningful while a grant is held.
  assign w_own       = r_gnt[1];
  assign w_oth       = ~w_own;
  assign w_beat      = |(req & r_gnt);
  assign w_addr      = w_own ? addr1 : addr0;
  assign w_data      = w_own ? data1 : data0;
  assign w_last      = w_own ? last1 : last0;
  assign w_addr_ok   = 32'(w_addr) < DEPTH;
  assign w_oth_state = w_own ? S_OWN0 : S_OWN1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rr_nxt    = r_rr;
    w_we_nxt    = '0;
    w_wdata_nxt = r_wdata;
    w_err_nxt   = 1'b0;

    if (w_beat) begin
      if (w_addr_ok) begin
        w_we_nxt    = DEPTH'(1) << w_addr;
        w_wdata_nxt = w_data;
      end else begin
        w_err_nxt = 1'b1;
      end
    end

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (req[0] && (!req[1] || !r_rr)) begin
          w_state_nxt = S_OWN0;
        end else if (req[1]) begin
          w_state_nxt = S_OWN1;
        end
      end
      S_OWN0, S_OWN1: begin
        if (!req[w_own]) begin
          // Owner dropped its request without a final beat.
          w_cnt_nxt   = '0;
          w_rr_nxt    = w_oth;
          w_state_nxt = req[w_oth] ? w_oth_state : S_IDLE;
        end else if (w_last || (r_cnt == LAST_CNT)) begin
          w_cnt_nxt   = '0;
          w_rr_nxt    = w_oth;
          w_state_nxt = req[w_oth] ? w_oth_state : r_state;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Grant and busy are registered decodes of the next state.
  always_ff @(posedge C or negedge Rn) begin
    if (!Rn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rr    <= 1'b0;
      r_gnt   <= 2'b00;
      r_busy  <= 1'b0;
      r_we    <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rr    <= w_rr_nxt;
      r_gnt   <= {w_state_nxt == S_OWN1, w_state_nxt == S_OWN0};
      r_busy  <= w_state_nxt != S_IDLE;
      r_we    <= w_we_nxt;
      r_wdata <= w_wdata_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign gnt   = r_gnt;
  assign we    = r_we;
  assign wdata = r_wdata;
  assign err   = r_err;
  assign busy  = r_busy;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter (DEPTH=6 so out-of-range addresses are reachable).
module tb_reg_bank_arbiter;

  localparam int unsigned DEPTH    = 6;
  localparam int unsigned AW       = 3;
  localparam int unsigned WIDTH    = 34;
  localparam int unsigned MAXBURST = 4;

  logic             C;
  logic             Rn;
  logic [1:0]       req;
  logic [AW-1:0]    addr0;
  logic [WIDTH-1:0] data0;
  logic             last0;
  logic [AW-1:0]    addr1;
  logic [WIDTH-1:0] data1;
  logic             last1;
  logic [1:0]       gnt;
  logic [DEPTH-1:0] we;
  logic [WIDTH-1:0] wdata;
  logic             err;
  logic             busy;

  int               n_checks;
  int               n_fail;
  logic [WIDTH-1:0] exp_wdata;

  reg_bank_arbiter #(
    .DEPTH(DEPTH), .AW(AW), .WIDTH(WIDTH), .MAXBURST(MAXBURST)
  ) dut (
    .C(C), .Rn(Rn), .req(req),
    .addr0(addr0), .data0(data0), .last0(last0),
    .addr1(addr1), .data1(data1), .last1(last1),
    .gnt(gnt), .we(we), .wdata(wdata), .err(err), .busy(busy)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [1:0] e_gnt,
                      input logic [DEPTH-1:0] e_we, input logic e_err);
    check({tag, ".gnt"},   64'(gnt),   64'(e_gnt));
    check({tag, ".we"},    64'(we),    64'(e_we));
    check({tag, ".err"},   64'(err),   64'(e_err));
    check({tag, ".busy"},  64'(busy),  64'(|e_gnt));
    check({tag, ".wdata"}, 64'(wdata), 64'(exp_wdata));
  endtask

  task automatic step;
    @(posedge C);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    exp_wdata = '0;
    Rn = 1'b0; req = 2'b00;
    addr0 = '0; data0 = '0; last0 = 1'b0;
    addr1 = '0; data1 = '0; last1 = 1'b0;
    repeat (2) step;
    outs("reset", 2'b00, 6'b000000, 1'b0);
    Rn = 1'b1;

    // Single-beat burst; req still high at the beat re-grants, then drop abandons.
    req = 2'b01; addr0 = 3'd5; data0 = 34'h2_DEAD_BEEF; last0 = 1'b1;
    step; outs("single_gnt", 2'b01, 6'b000000, 1'b0);
    step; exp_wdata = 34'h2_DEAD_BEEF; outs("single_wr", 2'b01, 6'b100000, 1'b0);
    req = 2'b00; last0 = 1'b0;
    step; outs("single_idle", 2'b00, 6'b000000, 1'b0);

    // Six beats from port 0 alone: split after four, re-granted with no gap.
    req = 2'b01;
    step; outs("split_gnt", 2'b01, 6'b000000, 1'b0);
    for (int b = 0; b < 6; b++) begin
      addr0 = AW'(b); data0 = 34'h1_0000_0000 + 34'(b);
      step; exp_wdata = data0;
      outs("split_beat", 2'b01, DEPTH'(1) << b, 1'b0);
    end
    req = 2'b00;
    step; outs("split_idle", 2'b00, 6'b000000, 1'b0);

    // Async reset while a write strobe is active.
    req = 2'b01; addr0 = 3'd2; data0 = 34'h3_1234_5678;
    step; outs("prerst_gnt", 2'b01, 6'b000000, 1'b0);
    step; exp_wdata = 34'h3_1234_5678; outs("prerst_wr", 2'b01, 6'b000100, 1'b0);
    Rn = 1'b0;
    #1; exp_wdata = '0; outs("async_rst", 2'b00, 6'b000000, 1'b0);
    req = 2'b00;
    step; outs("rst_hold", 2'b00, 6'b000000, 1'b0);
    Rn = 1'b1;

    // Contention from reset: port 0 first, forced split hands over to port 1.
    req = 2'b11; last0 = 1'b0; last1 = 1'b0;
    step; outs("rr_first", 2'b01, 6'b000000, 1'b0);
    for (int b = 0; b < 4; b++) begin
      addr0 = AW'(b); data0 = 34'h0_AAAA_0000 + 34'(b);
      step; exp_wdata = data0;
      outs("cont_p0", (b == 3) ? 2'b10 : 2'b01, DEPTH'(1) << b, 1'b0);
    end
    addr1 = 3'd3; data1 = 34'h0_BBBB_0000;
    step; exp_wdata = data1; outs("cont_p1a", 2'b10, 6'b001000, 1'b0);
    addr1 = 3'd4; data1 = 34'h0_BBBB_0001; last1 = 1'b1;
    step; exp_wdata = data1; outs("cont_p1b", 2'b01, 6'b010000, 1'b0);
    last1 = 1'b0;
    addr0 = 3'd2; data0 = 34'h0_CCCC_0000; last0 = 1'b1;
    step; exp_wdata = data0; outs("cont_p0b", 2'b10, 6'b000100, 1'b0);
    last0 = 1'b0; req = 2'b00;
    step; outs("cont_idle", 2'b00, 6'b000000, 1'b0);

    // Out-of-range addresses 7 and 6 count as beats but do not write.
    req = 2'b10;
    step; outs("bad_gnt", 2'b10, 6'b000000, 1'b0);
    addr1 = 3'd7; data1 = 34'h0_DDDD_0007;
    step; outs("bad_addr7", 2'b10, 6'b000000, 1'b1);
    addr1 = 3'd6; data1 = 34'h0_DDDD_0006;
    step; outs("bad_addr6", 2'b10, 6'b000000, 1'b1);
    addr1 = 3'd1; data1 = 34'h3_EEEE_0001; last1 = 1'b1;
    step; exp_wdata = data1; outs("bad_then_ok", 2'b10, 6'b000010, 1'b0);
    last1 = 1'b0;

    // Port 1 abandons with port 0 waiting; then port 0 abandons to idle.
    req = 2'b01;
    step; outs("abandon", 2'b01, 6'b000000, 1'b0);
    req = 2'b00;
    step; outs("abandon_idle", 2'b00, 6'b000000, 1'b0);

    // Pointer now favours port 1 under contention.
    req = 2'b11;
    step; outs("rr_p1", 2'b10, 6'b000000, 1'b0);
    req = 2'b00;
    step; outs("end_idle", 2'b00, 6'b000000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
